// File: rtl/vio_route_rx.sv
// Receive end of the vFPGA route switch: latches the route word per packet, forwards packets addressed
// to this region through a single registered output stage, discards misrouted ones and keeps statistics.
module vio_route_rx #(
  parameter int DATA_BITS  = 512,
  parameter int PID_BITS   = 6,
  parameter int ROUTE_BITS = 14,
  parameter int REGION_ID  = 0,
  parameter int CNT_BITS   = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  // routed stream from the switch
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [DATA_BITS-1:0]   s_tdata,
  input  logic [DATA_BITS/8-1:0] s_tkeep,
  input  logic                   s_tlast,
  input  logic [PID_BITS-1:0]    s_tid,
  input  logic [ROUTE_BITS-1:0]  s_tdest,
  // stream to user logic
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [DATA_BITS-1:0]   m_tdata,
  output logic [DATA_BITS/8-1:0] m_tkeep,
  output logic                   m_tlast,
  output logic [PID_BITS-1:0]    m_tid,
  // control plane
  output logic [ROUTE_BITS-1:0]  route_cur,
  output logic [CNT_BITS-1:0]    pkt_cnt,
  output logic [CNT_BITS-1:0]    drop_cnt,
  output logic                   err_route_chg
);

  localparam logic [2:0] REGION_SEL = 3'(REGION_ID);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // next accepted beat is a packet head
    ST_PASS = 2'd1,  // inside a packet addressed to this region
    ST_DROP = 2'd2   // inside a misrouted packet
  } state_t;

  state_t state, state_nxt;

  logic s_fire;
  logic m_fire;
  logic is_head;
  logic dest_hit;
  logic fwd;
  logic drop_head;
  logic route_mismatch;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  // Ready depends only on registered state and m_tready, never on s_tvalid.
  assign s_tready = (state == ST_DROP) | ~m_tvalid | m_tready;
  assign s_fire   = s_tvalid & s_tready;
  assign m_fire   = m_tvalid & m_tready;

  assign is_head        = (state == ST_IDLE);
  assign dest_hit       = (s_tdest[5:3] == REGION_SEL);
  assign fwd            = s_fire & ((is_head & dest_hit) | (state == ST_PASS));
  assign drop_head      = s_fire & is_head & ~dest_hit;
  assign route_mismatch = s_fire & ~is_head & (s_tdest != route_cur);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (s_fire && !s_tlast) begin
          state_nxt = dest_hit ? ST_PASS : ST_DROP;
        end
      end
      ST_PASS, ST_DROP: begin
        if (s_fire && s_tlast) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Single-entry output stage; a forward on the same edge as a drain keeps it full.
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: the data registers are reset too, so user logic sees all-zero outputs while in reset.
    if (!aresetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tid    <= '0;
    end else if (fwd) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata;
      m_tkeep  <= s_tkeep;
      m_tlast  <= s_tlast;
      m_tid    <= s_tid;
    end else if (m_fire) begin
      m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      route_cur     <= '0;
      err_route_chg <= 1'b0;
    end else begin
      if (s_fire && is_head) begin
        route_cur <= s_tdest;
      end
      // Sticky; the beat itself still follows the decision latched at the head.
      if (route_mismatch) begin
        err_route_chg <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (fwd && s_tlast) begin
        pkt_cnt <= sat_inc(pkt_cnt);
      end
      if (drop_head) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_vio_route_rx.sv
// Bench for vio_route_rx: directed packets against a packet-level model (expected-beat queue, counts),
// compared every cycle, plus literal expectations after each scenario.
module tb_vio_route_rx;

  localparam int DATA_BITS  = 32;
  localparam int KEEP_BITS  = DATA_BITS / 8;
  localparam int PID_BITS   = 6;
  localparam int ROUTE_BITS = 14;
  localparam int REGION_ID  = 2;
  localparam int CNT_BITS   = 3;
  localparam int CNT_MAX    = (1 << CNT_BITS) - 1;

  logic                  aclk = 1'b0;
  logic                  aresetn = 1'b1;
  logic                  s_tvalid = 1'b0;
  logic                  s_tready;
  logic [DATA_BITS-1:0]  s_tdata = '0;
  logic [KEEP_BITS-1:0]  s_tkeep = '0;
  logic                  s_tlast = 1'b0;
  logic [PID_BITS-1:0]   s_tid = '0;
  logic [ROUTE_BITS-1:0] s_tdest = '0;
  logic                  m_tvalid;
  logic                  m_tready = 1'b1;
  logic [DATA_BITS-1:0]  m_tdata;
  logic [KEEP_BITS-1:0]  m_tkeep;
  logic                  m_tlast;
  logic [PID_BITS-1:0]   m_tid;
  logic [ROUTE_BITS-1:0] route_cur;
  logic [CNT_BITS-1:0]   pkt_cnt;
  logic [CNT_BITS-1:0]   drop_cnt;
  logic                  err_route_chg;

  vio_route_rx #(
    .DATA_BITS (DATA_BITS),
    .PID_BITS  (PID_BITS),
    .ROUTE_BITS(ROUTE_BITS),
    .REGION_ID (REGION_ID),
    .CNT_BITS  (CNT_BITS)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tdata      (s_tdata),
    .s_tkeep      (s_tkeep),
    .s_tlast      (s_tlast),
    .s_tid        (s_tid),
    .s_tdest      (s_tdest),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .m_tkeep      (m_tkeep),
    .m_tlast      (m_tlast),
    .m_tid        (m_tid),
    .route_cur    (route_cur),
    .pkt_cnt      (pkt_cnt),
    .drop_cnt     (drop_cnt),
    .err_route_chg(err_route_chg)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [KEEP_BITS-1:0] keep;
    logic                 last;
    logic [PID_BITS-1:0]  id;
  } beat_t;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;
  int seq      = 0;

  // Packet-level model: beats owed to user logic, packet/drop totals, latched route, error flag.
  beat_t                 exp_q[$];
  beat_t                 mon_b;
  bit                    in_pkt   = 1'b0;
  bit                    keep_pkt = 1'b0;
  logic [ROUTE_BITS-1:0] mdl_route = '0;
  bit                    mdl_err  = 1'b0;
  int                    mdl_pkts = 0;
  int                    mdl_drops = 0;
  int                    m_beats  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      exp_q.delete();
      in_pkt    = 1'b0;
      keep_pkt  = 1'b0;
      mdl_route = '0;
      mdl_err   = 1'b0;
      mdl_pkts  = 0;
      mdl_drops = 0;
    end else begin
      if (m_tvalid && m_tready) begin
        m_beats++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (s_tvalid && s_tready) begin
        if (!in_pkt) begin
          mdl_route = s_tdest;
          keep_pkt  = (s_tdest[5:3] == 3'(REGION_ID));
          if (!keep_pkt) mdl_drops++;
        end else if (s_tdest != mdl_route) begin
          mdl_err = 1'b1;
        end
        if (keep_pkt) begin
          mon_b.data = s_tdata;
          mon_b.keep = s_tkeep;
          mon_b.last = s_tlast;
          mon_b.id   = s_tid;
          exp_q.push_back(mon_b);
          if (s_tlast) mdl_pkts++;
        end
        in_pkt = !s_tlast;
      end
    end
  end

  always @(negedge aclk) begin
    if (started && aresetn) begin
      check("m_tvalid", 64'(m_tvalid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("m_tdata", 64'(m_tdata), 64'(exp_q[0].data));
        check("m_tkeep", 64'(m_tkeep), 64'(exp_q[0].keep));
        check("m_tlast", 64'(m_tlast), 64'(exp_q[0].last));
        check("m_tid",   64'(m_tid),   64'(exp_q[0].id));
      end
      check("s_tready", 64'(s_tready),
            64'((in_pkt && !keep_pkt) || exp_q.size() == 0 || m_tready));
      check("pkt_cnt",       64'(pkt_cnt),       64'(sat(mdl_pkts)));
      check("drop_cnt",      64'(drop_cnt),      64'(sat(mdl_drops)));
      check("route_cur",     64'(route_cur),     64'(mdl_route));
      check("err_route_chg", 64'(err_route_chg), 64'(mdl_err));
    end
  end

  task automatic drive(input logic [ROUTE_BITS-1:0] dest, input logic last, input logic [PID_BITS-1:0] id);
    seq++;
    s_tvalid = 1'b1;
    s_tdata  = {8'(id), 24'(seq)};
    s_tkeep  = 4'(seq) | 4'b0001;
    s_tlast  = last;
    s_tid    = id;
    s_tdest  = dest;
  endtask

  task automatic send_beat(input logic [ROUTE_BITS-1:0] dest, input logic last, input logic [PID_BITS-1:0] id);
    logic ok;
    int   budget;
    drive(dest, last, id);
    ok = 1'b0;
    budget = 0;
    while (!ok && budget < 50) begin
      @(negedge aclk);
      ok = s_tready;
      @(posedge aclk);
      #1;
      budget++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: beat not accepted within 50 cycles, got s_tready=%0b want 1", s_tready);
    end
  endtask

  task automatic send_pkt(input logic [ROUTE_BITS-1:0] dest, input int beats, input logic [PID_BITS-1:0] id);
    for (int i = 0; i < beats; i++) send_beat(dest, i == beats - 1, id);
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  int base;

  initial begin
    #2 aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata",  64'(m_tdata),  64'd0);
    check("rst_pkt_cnt",  64'(pkt_cnt),  64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_route",    64'(route_cur), 64'd0);
    check("rst_err",      64'(err_route_chg), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd1);
    aresetn = 1'b1;
    started = 1'b1;
    idle(2);

    // 4-beat packet to this region
    base = m_beats;
    send_pkt(14'h0010, 4, 6'd1);
    idle(3);
    check("t1_beats", 64'(m_beats - base), 64'd4);
    check("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
    check("t1_route", 64'(route_cur), 64'h0010);

    // 3-beat misrouted packet
    base = m_beats;
    send_pkt(14'h0018, 3, 6'd2);
    idle(3);
    check("t2_beats", 64'(m_beats - base), 64'd0);
    check("t2_drop_cnt", 64'(drop_cnt), 64'd1);
    check("t2_route", 64'(route_cur), 64'h0018);

    // backpressure mid-packet
    base = m_beats;
    fork
      send_pkt(14'h0010, 6, 6'd3);
      begin
        repeat (2) @(posedge aclk);
        #1 m_tready = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("t3_stall_s_tready", 64'(s_tready), 64'd0);
        check("t3_stall_m_tvalid", 64'(m_tvalid), 64'd1);
        repeat (2) @(posedge aclk);
        #1 m_tready = 1'b1;
      end
    join
    idle(3);
    check("t3_beats", 64'(m_beats - base), 64'd6);
    check("t3_pkt_cnt", 64'(pkt_cnt), 64'd2);

    // back-to-back single-beat packets
    base = m_beats;
    send_beat(14'h0010, 1'b1, 6'd4);
    send_beat(14'h0018, 1'b1, 6'd5);
    send_beat(14'h0010, 1'b1, 6'd6);
    idle(3);
    check("t4_beats", 64'(m_beats - base), 64'd2);
    check("t4_pkt_cnt", 64'(pkt_cnt), 64'd4);
    check("t4_drop_cnt", 64'(drop_cnt), 64'd2);

    // route word changes inside a forwarded packet
    base = m_beats;
    send_beat(14'h0010, 1'b0, 6'd7);
    send_beat(14'h0011, 1'b0, 6'd7);
    send_beat(14'h0010, 1'b1, 6'd7);
    idle(3);
    check("t5_beats", 64'(m_beats - base), 64'd3);
    check("t5_err", 64'(err_route_chg), 64'd1);
    check("t5_route", 64'(route_cur), 64'h0010);
    send_pkt(14'h0010, 2, 6'd8);
    idle(3);
    check("t5_err_sticky", 64'(err_route_chg), 64'd1);
    check("t5_pkt_cnt", 64'(pkt_cnt), 64'd6);

    // saturation of both counters
    for (int i = 0; i < 3; i++) send_beat(14'h0010, 1'b1, 6'd9);
    for (int i = 0; i < 6; i++) send_beat(14'h0018, 1'b1, 6'd10);
    idle(3);
    check("t6_pkt_sat", 64'(pkt_cnt), 64'(CNT_MAX));
    check("t6_drop_sat", 64'(drop_cnt), 64'(CNT_MAX));

    // reset during beat 2 of 4
    send_beat(14'h0010, 1'b0, 6'd11);
    drive(14'h0010, 1'b0, 6'd11);
    #2 aresetn = 1'b0;
    #1;
    check("t7_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("t7_rst_m_tdata",  64'(m_tdata),  64'd0);
    check("t7_rst_pkt_cnt",  64'(pkt_cnt),  64'd0);
    check("t7_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("t7_rst_route",    64'(route_cur), 64'd0);
    check("t7_rst_err",      64'(err_route_chg), 64'd0);
    s_tvalid = 1'b0;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    idle(1);
    base = m_beats;
    send_pkt(14'h0010, 4, 6'd12);
    idle(3);
    check("t7_beats", 64'(m_beats - base), 64'd4);
    check("t7_pkt_cnt", 64'(pkt_cnt), 64'd1);
    check("t7_drop_cnt", 64'(drop_cnt), 64'd0);
    check("t7_route", 64'(route_cur), 64'h0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
